mem_io_responder: RTL and testbench

- Responder end of the CPU's byte-wide memory bus (mem_a / mem_dout / mem_wr in, mem_din out): 128 KB RAM plus the 0x3xxxx I/O window.
- Read data is returned one cycle after the request. A write takes effect in the cycle it is presented.
- Drives io_buffer_full back to the CPU. Drains bytes written to 0x30000 through a TX FIFO with a valid/ready byte stream.
- Provides the 0x30004 cycle counter and the program-stop flag. Used in simulation top and FPGA top.

---
 rtl/mem_io_responder.sv | 122 ++++++++++++
 tb/tb_mem_io_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: 128 KB RAM, 0x3xxxx I/O window, TX FIFO, cycle counter, stop flag.
// Optional macro MEM_IO_ADDR_CHECK_EN: treats 0x2xxxx as an error region and raises addr_err.
module mem_io_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_stop,
    output logic        addr_err
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    ram  [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]    fifo [0:TX_DEPTH-1];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   counter, snapshot;

    logic          io, err_rgn, ram_we, push_req, push, pop;
    logic [15:0]   io_off;
    logic [7:0]    push_byte;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^mem_a[31:18];
    assign io     = (mem_a[17:16] == 2'b11);
    assign io_off = mem_a[15:0];

`ifdef MEM_IO_ADDR_CHECK_EN
    assign err_rgn = (mem_a[17:16] == 2'b10);
`else
    assign err_rgn = 1'b0;
`endif

    assign ram_we    = rdy_in & mem_wr & ~io & ~err_rgn;
    assign push_req  = rdy_in & mem_wr & io &
                       (((io_off == 16'h0000) && (mem_dout != 8'h00)) || (io_off == 16'h0004));
    assign push_byte = (io_off == 16'h0004) ? 8'h00 : mem_dout;

    assign tx_valid = (count != '0);
    assign tx_data  = fifo[rptr];
    assign pop      = rdy_in & tx_valid & tx_ready;
    // a concurrent pop frees a slot, so a push into a full FIFO still lands
    assign push       = push_req & ((count != CW'(TX_DEPTH)) | pop);
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
        if (push)   fifo[wptr] <= push_byte;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_din        <= 8'h00;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            rx_pop         <= 1'b0;
            program_stop   <= 1'b0;
            counter        <= 32'h0;
            snapshot       <= 32'h0;
        end else if (rdy_in) begin
            counter <= counter + 32'd1;
            rx_pop  <= 1'b0;
            if (!mem_wr) begin
                if (io) begin
                    case (io_off)
                        16'h0000: begin
                            mem_din <= rx_valid ? rx_data : 8'h00;
                            rx_pop  <= rx_valid;
                        end
                        16'h0004: begin
                            mem_din  <= counter[7:0];
                            snapshot <= counter;
                        end
                        16'h0005: mem_din <= snapshot[15:8];
                        16'h0006: mem_din <= snapshot[23:16];
                        16'h0007: mem_din <= snapshot[31:24];
                        default:  mem_din <= 8'h00;
                    endcase
                end else if (err_rgn) begin
                    mem_din <= 8'h00;
                end else begin
                    mem_din <= ram[mem_a[ADDR_WIDTH-1:0]];
                end
            end else if (io && io_off == 16'h0004) begin
                program_stop <= 1'b1;
            end
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count          <= count_next;
            io_buffer_full <= (count_next >= CW'(TX_DEPTH - FULL_MARGIN));
        end else begin
            rx_pop <= 1'b0;
        end
    end

`ifdef MEM_IO_ADDR_CHECK_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in)                 addr_err <= 1'b0;
        else if (rdy_in && err_rgn)  addr_err <= 1'b1;
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic        program_stop;
    logic        addr_err;

    localparam int DEPTH = 8;
    localparam int THR   = 6;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_stop(program_stop), .addr_err(addr_err)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [7:0]  mram [int];
    logic [7:0]  mq [$];
    logic [31:0] m_cnt = 0, m_snap = 0;
    logic [7:0]  m_din = 0;
    logic        m_known = 1, m_pop = 0, m_stop = 0, m_full = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        logic [17:0] o;
        int k;
        o = mem_a[17:0];
        k = int'(o[16:0]);
        m_pop = 0;
        if (rdy_in) begin
            if (tx_ready && mq.size() > 0) void'(mq.pop_front());
            if (mem_wr) begin
                if (o[17:16] == 2'b11) begin
                    if (o == 18'h30000 && mem_dout != 0 && mq.size() < DEPTH) mq.push_back(mem_dout);
                    if (o == 18'h30004) begin
                        m_stop = 1;
                        if (mq.size() < DEPTH) mq.push_back(8'h00);
                    end
                end else begin
                    mram[k] = mem_dout;
                end
            end else begin
                m_known = 1;
                if (o[17:16] == 2'b11) begin
                    case (o)
                        18'h30000: begin m_din = rx_valid ? rx_data : 8'h00; m_pop = rx_valid; end
                        18'h30004: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
                        18'h30005: m_din = m_snap[15:8];
                        18'h30006: m_din = m_snap[23:16];
                        18'h30007: m_din = m_snap[31:24];
                        default:   m_din = 8'h00;
                    endcase
                end else if (mram.exists(k)) begin
                    m_din = mram[k];
                end else begin
                    m_known = 0;
                end
            end
            m_cnt = m_cnt + 1;
            m_full = (mq.size() >= THR);
        end
    endtask

    task automatic check_model();
        chk("tx_valid", tx_valid, mq.size() != 0);
        if (mq.size() != 0) chk("tx_data", tx_data, mq[0]);
        chk("io_buffer_full", io_buffer_full, m_full);
        chk("rx_pop", rx_pop, m_pop);
        chk("program_stop", program_stop, m_stop);
        chk("addr_err", addr_err, 1'b0);
        if (m_known) chk("mem_din", mem_din, m_din);
    endtask

    task automatic cyc(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d,
                       input logic txr, input logic rxv, input logic [7:0] rxd);
        rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge clk_in);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_in = 0; rdy_in = 1; mem_wr = 0; mem_a = 32'h30008;
        tx_ready = 0; rx_valid = 0;
        @(posedge clk_in);
        mq.delete();
        m_cnt = 0; m_snap = 0; m_din = 0; m_known = 1;
        m_pop = 0; m_stop = 0; m_full = 0;
        #1;
        rst_in = 1;
        check_model();
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  e_din;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_pop;
    } vec_t;

    vec_t tv [11];

    initial begin
        tv[0]  = '{1'b1, 32'h00010, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[1]  = '{1'b0, 32'h00010, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0};
        tv[2]  = '{1'b1, 32'h30000, 8'h41, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 8'h41, 1'b0};
        tv[3]  = '{1'b1, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 8'h41, 1'b0};
        tv[4]  = '{1'b1, 32'h30000, 8'h42, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 8'h41, 1'b0};
        tv[5]  = '{1'b0, 32'h30008, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h42, 1'b0};
        tv[6]  = '{1'b0, 32'h30008, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[7]  = '{1'b0, 32'h30000, 8'h00, 1'b0, 1'b1, 8'h37, 8'h37, 1'b0, 8'h00, 1'b1};
        tv[8]  = '{1'b0, 32'h30008, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[9]  = '{1'b1, 32'h30004, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
        tv[10] = '{1'b0, 32'h30008, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        // reset state
        do_reset();
        chk("rst mem_din", mem_din, 8'h00);
        chk("rst tx_valid", tx_valid, 1'b0);
        chk("rst full", io_buffer_full, 1'b0);
        chk("rst program_stop", program_stop, 1'b0);
        chk("rst rx_pop", rx_pop, 1'b0);

        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, tv[i].wr, tv[i].a, tv[i].d, tv[i].txr, tv[i].rxv, tv[i].rxd);
            chk($sformatf("vec%0d mem_din", i), mem_din, tv[i].e_din);
            chk($sformatf("vec%0d tx_valid", i), tx_valid, tv[i].e_txv);
            if (tv[i].e_txv) chk($sformatf("vec%0d tx_data", i), tx_data, tv[i].e_txd);
            chk($sformatf("vec%0d rx_pop", i), rx_pop, tv[i].e_pop);
        end
        chk("stop after write", program_stop, 1'b1);

        // fill to near-full, overflow, then drain in order
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b1, 1'b1, 32'h30000, 8'(k), 1'b0, 1'b0, 8'h00);
            if (k == 5) chk("full after 5", io_buffer_full, 1'b0);
            if (k == 6) chk("full after 6", io_buffer_full, 1'b1);
        end
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain %0d", k), tx_data, 32'(k));
            cyc(1'b1, 1'b0, 32'h30008, 8'h00, 1'b1, 1'b0, 8'h00);
        end
        chk("drained", tx_valid, 1'b0);

        // reset with queued bytes keeps RAM
        cyc(1'b1, 1'b1, 32'h01234, 8'h55, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 32'h30000, 8'(8'h11 + k), 1'b0, 1'b0, 8'h00);
        chk("queued 4", tx_valid, 1'b1);
        do_reset();
        chk("rst2 tx_valid", tx_valid, 1'b0);
        chk("rst2 full", io_buffer_full, 1'b0);
        chk("rst2 program_stop", program_stop, 1'b0);
        cyc(1'b1, 1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("rst2 counter", mem_din, 8'h00);
        cyc(1'b1, 1'b0, 32'h01234, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("ram survives reset", mem_din, 8'h55);

        // coherent counter snapshot and rdy_in freeze
        do_reset();
        for (int k = 0; k < 255; k++) cyc(1'b1, 1'b0, 32'h30008, 8'h00, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("cnt byte0", mem_din, 8'hFF);
        cyc(1'b1, 1'b0, 32'h30005, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("cnt byte1", mem_din, 8'h00);
        cyc(1'b1, 1'b0, 32'h30006, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("cnt byte2", mem_din, 8'h00);
        cyc(1'b1, 1'b0, 32'h30007, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("cnt byte3", mem_din, 8'h00);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 32'h30004, 8'h00, 1'b1, 1'b1, 8'h12);
        chk("rdy low din hold", mem_din, 8'h00);
        cyc(1'b1, 1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("cnt after freeze", mem_din, 8'h03);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic [7:0]  d;
            int sel;
            a = $urandom();
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: a[17:0] = 18'($urandom_range(0, 15));
                3:       a[17:0] = 18'h20000 | 18'($urandom_range(0, 15));
                4, 5:    a[17:0] = 18'h30000;
                6:       a[17:0] = 18'h30004;
                7:       a[17:0] = 18'h30005 + 18'($urandom_range(0, 2));
                8:       a[17:0] = 18'h30008;
                default: a[17:0] = 18'h30000;
            endcase
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            cyc($urandom_range(0, 99) < 85, 1'($urandom()), a, d,
                1'($urandom()), 1'($urandom()), 8'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
